// File: rtl/tetromino_spawn_ctrl_pkg.sv
// tetromino_spawn_ctrl_pkg: shared piece descriptor, piece indices and spawn FSM states.
package tetromino_spawn_ctrl_pkg;

   localparam logic [2:0] TETROMINO_I_IDX = 3'd0;
   localparam logic [2:0] TETROMINO_O_IDX = 3'd1;
   localparam logic [2:0] TETROMINO_T_IDX = 3'd2;
   localparam logic [2:0] TETROMINO_S_IDX = 3'd3;
   localparam logic [2:0] TETROMINO_Z_IDX = 3'd4;
   localparam logic [2:0] TETROMINO_J_IDX = 3'd5;
   localparam logic [2:0] TETROMINO_L_IDX = 3'd6;

   typedef struct packed {
      logic [2:0] idx;
      logic [1:0] rot;
      logic [3:0] col;
      logic [4:0] row;
   } tetromino_ctrl;

   typedef enum logic [2:0] {
      S_BOOT,
      S_WAIT,
      S_RETRY,
      S_CAPTURE,
      S_READY
   } spawn_state_e;

endpackage

// File: rtl/tetromino_spawn_ctrl_spawn_watchdog.sv
// spawn_watchdog: counts cycles while enabled and pulses expire on the last allowed cycle.
module spawn_watchdog #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      expire = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      cnt_d  = (!en || clr || expire) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

endmodule

// File: rtl/tetromino_spawn_ctrl.sv
// tetromino_spawn_ctrl: primes generate_tetromino, buffers current/preview pieces, serves spawns.
// Define HOLD_PIECE_EN to add the player hold slot.
module tetromino_spawn_ctrl
   import tetromino_spawn_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spawn_req,
   output logic          spawn_ack,
   output tetromino_ctrl t_spawn,
   output tetromino_ctrl t_preview,
   output logic          ready,
   output logic          gen_enable,
   input  logic          gen_done,
   input  tetromino_ctrl gen_t_curr,
   input  tetromino_ctrl gen_t_next,
`ifdef HOLD_PIECE_EN
   input  logic          hold_req,
   input  tetromino_ctrl hold_in,
   output logic          hold_nack,
   output tetromino_ctrl t_hold,
   output logic          hold_valid,
`endif
   output logic          err_timeout
);

   spawn_state_e  state_q, state_d;
   tetromino_ctrl cur_q, cur_d, prev_q, prev_d, t_spawn_q, swap_piece;
   logic          err_q, err_d, expire, in_wait, in_ready, hold_go, hold_swap, spawn_go;
`ifdef HOLD_PIECE_EN
   tetromino_ctrl hold_q, hold_d;
   logic          hold_valid_q, hold_valid_d, lock_q, lock_d;
`endif

   spawn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .en     (in_wait),
      .clr    (gen_done),
      .expire (expire)
   );

   always_comb begin
      in_wait  = state_q == S_WAIT;
      in_ready = state_q == S_READY;
`ifdef HOLD_PIECE_EN
      hold_go      = in_ready && hold_req && !lock_q;
      hold_swap    = hold_go && hold_valid_q;
      swap_piece   = hold_q;
      hold_nack    = hold_req && !hold_go;
      hold_d       = hold_go ? hold_in : hold_q;
      hold_valid_d = hold_valid_q || hold_go;
      lock_d       = hold_go || (lock_q && !(in_ready && spawn_req));
      t_hold       = hold_q;
      hold_valid   = hold_valid_q;
`else
      hold_go    = 1'b0;
      hold_swap  = 1'b0;
      swap_piece = '0;
`endif
      // Hold takes priority; an accepted hold always delivers a piece.
      spawn_go    = in_ready && spawn_req && !hold_go;
      spawn_ack   = spawn_go || hold_go;
      t_spawn     = hold_swap ? swap_piece : spawn_ack ? cur_q : t_spawn_q;
      gen_enable  = in_wait;
      ready       = in_ready;
      t_preview   = prev_q;
      err_timeout = err_q;
      state_d     = state_q == S_BOOT    ? S_WAIT :
                    in_wait              ? (gen_done ? S_CAPTURE : expire ? S_RETRY : S_WAIT) :
                    state_q == S_RETRY   ? S_WAIT :
                    state_q == S_CAPTURE ? S_READY :
                    in_ready             ? ((spawn_ack && !hold_swap) ? S_WAIT : S_READY) :
                                           S_BOOT;
      cur_d       = state_q == S_CAPTURE ? gen_t_curr : cur_q;
      prev_d      = state_q == S_CAPTURE ? gen_t_next : prev_q;
      err_d       = err_q || (in_wait && !gen_done && expire);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q   <= S_BOOT;
         cur_q     <= '0;
         prev_q    <= '0;
         t_spawn_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         prev_q    <= prev_d;
         t_spawn_q <= t_spawn;
         err_q     <= err_d;
      end

`ifdef HOLD_PIECE_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         lock_q       <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         lock_q       <= lock_d;
      end
`endif

endmodule

// File: tb/tb_tetromino_spawn_ctrl.sv
// tb_tetromino_spawn_ctrl: directed scoreboard bench with a 5-cycle generator model.
// Hold-slot steps run only when HOLD_PIECE_EN is defined.
module tb_tetromino_spawn_ctrl;
   import tetromino_spawn_ctrl_pkg::*;

   localparam int TO = 8;

   logic          clk = 1'b0, rst = 1'b1, spawn_req = 1'b0, gen_done = 1'b0;
   logic          spawn_ack, ready, gen_enable, err_timeout;
   tetromino_ctrl gen_t_curr = '0, gen_t_next = '0, t_spawn, t_preview;
`ifdef HOLD_PIECE_EN
   logic          hold_req = 1'b0, hold_nack, hold_valid;
   tetromino_ctrl hold_in = '0, t_hold, h3, h5;
`endif

   int            checks = 0, errors = 0, ack_cnt = 0, gen_cnt = 0;
   bit            gen_ok = 1'b1;
   tetromino_ctrl exp_q[$];
   tetromino_ctrl exp_cur = '0, exp_prev = '0, last_spawn = '0;

   always #5 clk = ~clk;

   tetromino_spawn_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .spawn_req   (spawn_req),
      .spawn_ack   (spawn_ack),
      .t_spawn     (t_spawn),
      .t_preview   (t_preview),
      .ready       (ready),
      .gen_enable  (gen_enable),
      .gen_done    (gen_done),
      .gen_t_curr  (gen_t_curr),
      .gen_t_next  (gen_t_next),
`ifdef HOLD_PIECE_EN
      .hold_req    (hold_req),
      .hold_in     (hold_in),
      .hold_nack   (hold_nack),
      .t_hold      (t_hold),
      .hold_valid  (hold_valid),
`endif
      .err_timeout (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic tetromino_ctrl rand_piece();
      tetromino_ctrl p;
      p.idx = 3'($urandom_range(0, 6));
      p.rot = 2'($urandom_range(0, 3));
      p.col = 4'($urandom_range(3, 6));
      p.row = '0;
      return p;
   endfunction

   // Generator model: done pulse on the 5th consecutive enabled cycle.
   initial begin
      int n = 0;
      forever begin
         @(posedge clk); #1;
         gen_done = 1'b0;
         if (rst || !gen_enable) n = 0;
         else begin
            n++;
            if (n == 5 && gen_ok) begin
               gen_t_curr = rand_piece();
               gen_t_next = rand_piece();
               gen_done   = 1'b1;
               exp_cur    = gen_t_curr;
               exp_prev   = gen_t_next;
               gen_cnt++;
            end
         end
      end
   end

   // Scoreboard monitor: every ack consumes one expected piece.
   initial forever begin
      tetromino_ctrl e;
      @(negedge clk);
      if (spawn_ack) begin
         ack_cnt++;
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL spurious_ack observed=1 expected=0");
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("t_spawn", 32'(t_spawn), 32'(e));
            last_spawn = e;
         end
      end
   end

   task automatic wait_ready(output bit ok);
      int n = 0;
      @(negedge clk);
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = ready;
   endtask

   task automatic do_spawn();
      bit ok;
      wait_ready(ok);
      chk("ready_before_spawn", 32'(ok), 1);
      @(posedge clk); #1;
      spawn_req = 1'b1;
      exp_q.push_back(exp_cur);
      @(negedge clk);
      chk("spawn_ack_high", 32'(spawn_ack), 1);
      @(posedge clk); #1;
      spawn_req = 1'b0;
      @(negedge clk);
      chk("spawn_ack_pulse", 32'(spawn_ack), 0);
      chk("regen_enable", 32'(gen_enable), 1);
   endtask

   initial begin
      bit ok;
      int a0, g0, n;
      #5;
      chk("reset_ctrl", 32'({spawn_ack, ready, gen_enable, err_timeout}), 0);
      chk("reset_t_spawn", 32'(t_spawn), 0);
      chk("reset_t_preview", 32'(t_preview), 0);
      #15 rst = 1'b0;

      wait_ready(ok);
      chk("first_ready", 32'(ok), 1);
      chk("ready_gen_off", 32'(gen_enable), 0);
      chk("first_preview", 32'(t_preview), 32'(exp_prev));
      chk("preview_idx_range", 32'(t_preview.idx < 3'd7), 1);

      do_spawn();
      chk("t_spawn_held", 32'(t_spawn), 32'(last_spawn));

      // Request raised during S_WAIT stays pending until S_READY.
      @(posedge clk); #1;
      spawn_req = 1'b1;
      a0 = ack_cnt;
      g0 = gen_cnt;
      n = 0;
      while (gen_cnt == g0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("pending_gen_done", 32'(gen_cnt != g0), 1);
      chk("pending_no_early_ack", 32'(ack_cnt), 32'(a0));
      exp_q.push_back(exp_cur);
      n = 0;
      while (ack_cnt == a0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      spawn_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("pending_single_ack", 32'(ack_cnt), 32'(a0 + 1));

`ifdef HOLD_PIECE_EN
      h3 = '0; h3.idx = TETROMINO_S_IDX; h3.col = 4'd4;
      h5 = '0; h5.idx = TETROMINO_J_IDX; h5.col = 4'd5;
      wait_ready(ok);
      chk("hold_ready", 32'(ok), 1);
      @(posedge clk); #1;
      hold_in = h3; hold_req = 1'b1;
      exp_q.push_back(exp_cur);
      @(negedge clk);
      chk("hold_empty_ack", 32'(spawn_ack), 1);
      chk("hold_empty_no_nack", 32'(hold_nack), 0);
      @(posedge clk); #1;
      hold_req = 1'b0;
      @(negedge clk);
      chk("hold_valid", 32'(hold_valid), 1);
      chk("t_hold_idx3", 32'(t_hold.idx), 3);
      chk("hold_empty_regen", 32'(gen_enable), 1);
      @(posedge clk); #1;
      hold_req = 1'b1;
      @(negedge clk);
      chk("hold_second_nack", 32'(hold_nack), 1);
      chk("hold_second_no_ack", 32'(spawn_ack), 0);
      @(posedge clk); #1;
      hold_req = 1'b0;
      do_spawn();
      wait_ready(ok);
      @(posedge clk); #1;
      hold_in = h5; hold_req = 1'b1;
      exp_q.push_back(h3);
      @(negedge clk);
      chk("hold_full_ack", 32'(spawn_ack), 1);
      @(posedge clk); #1;
      hold_req = 1'b0;
      @(negedge clk);
      chk("t_hold_idx5", 32'(t_hold.idx), 5);
      chk("hold_full_stay_ready", 32'({ready, gen_enable}), 32'(2'b10));
      @(posedge clk); #1;
      hold_req = 1'b1;
      @(negedge clk);
      chk("hold_locked_nack", 32'(hold_nack), 1);
      @(posedge clk); #1;
      hold_req = 1'b0;
`endif

      // Generator stalls: watchdog retry after TO cycles in S_WAIT.
      wait_ready(ok);
      gen_ok = 1'b0;
      do_spawn();
      repeat (TO - 1) begin
         @(negedge clk);
         chk("wait_no_timeout", 32'({err_timeout, gen_enable}), 32'(2'b01));
      end
      @(negedge clk);
      chk("timeout_err", 32'(err_timeout), 1);
      chk("retry_enable_low", 32'(gen_enable), 0);
      gen_ok = 1'b1;
      @(negedge clk);
      chk("retry_one_cycle", 32'(gen_enable), 1);
      wait_ready(ok);
      chk("ready_after_retry", 32'(ok), 1);
      chk("preview_after_retry", 32'(t_preview), 32'(exp_prev));
      do_spawn();
      chk("err_sticky", 32'(err_timeout), 1);

      // Asynchronous reset in the middle of S_WAIT.
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_gen_enable", 32'(gen_enable), 0);
      chk("rst_ctrl", 32'({spawn_ack, ready, err_timeout}), 0);
      chk("rst_bufs", 32'({t_spawn, t_preview}), 0);
`ifdef HOLD_PIECE_EN
      chk("rst_hold", 32'({hold_valid, t_hold}), 0);
`endif
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_ready(ok);
      chk("ready_after_rst", 32'(ok), 1);
      do_spawn();
      repeat (2) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
